// File: rtl/ddma_mmio_regs_if.sv
// ddma_mmio_regs_if
// Bundles the CPU-side register bus and the DDMA send-engine handshake for
// the DDMA configuration window.
//   addr_in/data_in/wb_in : core byte address, write data, byte strobes
//   data_out              : registered-read data (one cycle after addr_in)
//   dest_out/addr_out/size_out : DDMA descriptor fields
//   start_out/start_ack_in     : send request handshake
//   send_done_in/recv_done_in  : completion pulses from the DDMA
//   irq_send_out/irq_recv_out/err_out : latched interrupts and sticky error
// slave  : the register block
// master : the core / DDMA side driving it
interface ddma_mmio_regs_if;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [3:0]  wb_in;
    logic [31:0] data_out;
    logic [31:0] dest_out;
    logic [31:0] addr_out;
    logic [31:0] size_out;
    logic        start_out;
    logic        start_ack_in;
    logic        send_done_in;
    logic        recv_done_in;
    logic        irq_send_out;
    logic        irq_recv_out;
    logic        err_out;

    modport slave (
        input  addr_in, data_in, wb_in, start_ack_in, send_done_in, recv_done_in,
        output data_out, dest_out, addr_out, size_out, start_out,
               irq_send_out, irq_recv_out, err_out
    );

    modport master (
        output addr_in, data_in, wb_in, start_ack_in, send_done_in, recv_done_in,
        input  data_out, dest_out, addr_out, size_out, start_out,
               irq_send_out, irq_recv_out, err_out
    );
endinterface

// File: rtl/ddma_mmio_regs.sv
// ddma_mmio_regs
// Clocked register slave for the DDMA configuration window
// (BASE_ADDR .. BASE_ADDR+'h17, six words). Holds the descriptor registers,
// runs the send-request handshake, latches completion interrupts and returns
// read data one cycle after the address.
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-high reset
//   bus    : ddma_mmio_regs_if.slave (core bus + DDMA handshake)
// The core presents words in the opposite byte order to the registers:
// core byte lane k corresponds to register byte 3-k, both on write and read.
//
// Send FSM:
//   state  | meaning
//   S_IDLE | no request outstanding, descriptor writable
//   S_REQ  | start_out high, waiting for start_ack_in
//   S_BUSY | DDMA accepted, waiting for send_done_in
module ddma_mmio_regs #(
    parameter int          MEMORY_WIDTH = 32,
    parameter logic [31:0] ADDRESS      = 32'h0,
    parameter logic [31:0] BASE_ADDR    = 32'h2000_0000
) (
    input  logic              clock,
    input  logic              reset,
    ddma_mmio_regs_if.slave   bus
);

    localparam int          DW        = MEMORY_WIDTH;
    localparam logic [31:0] LAST_WORD = BASE_ADDR + 32'h14;

    localparam logic [2:0] OFF_ID     = 3'd0;
    localparam logic [2:0] OFF_DEST   = 3'd1;
    localparam logic [2:0] OFF_SRC    = 3'd2;
    localparam logic [2:0] OFF_SIZE   = 3'd3;
    localparam logic [2:0] OFF_CMD    = 3'd4;
    localparam logic [2:0] OFF_STATUS = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_BUSY = 3'd2
    } state_t;

    function automatic logic [31:0] f_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    state_t        r_state;
    logic          r_start;
    logic [DW-1:0] r_dest;
    logic [DW-1:0] r_src;
    logic [DW-1:0] r_size;
    logic          r_irq_send;
    logic          r_irq_recv;
    logic          r_err;
    logic          r_rd_hit;
    logic [2:0]    r_rd_off;

    logic [31:0]   w_aligned;
    logic          w_hit;
    logic [2:0]    w_off;
    logic [31:0]   w_wdata;
    logic [31:0]   w_mask;
    logic          w_wr;
    logic          w_wr_cfg;
    logic          w_wr_cmd;
    logic          w_wr_stat;
    logic          w_idle;
    logic          w_set_send;
    logic          w_set_err;
    logic          w_clr_send;
    logic          w_clr_recv;
    logic          w_clr_err;
    logic [31:0]   w_status;
    logic [31:0]   w_rd_word;

    assign w_aligned = bus.addr_in & ~32'h3;
    assign w_hit     = (w_aligned >= BASE_ADDR) && (w_aligned <= LAST_WORD);
    assign w_off     = 3'((bus.addr_in - BASE_ADDR) >> 2);

    // Register-order data and per-byte mask (strobe lane k -> register byte 3-k).
    assign w_wdata   = f_swap(bus.data_in);
    assign w_mask    = {{8{bus.wb_in[0]}}, {8{bus.wb_in[1]}},
                        {8{bus.wb_in[2]}}, {8{bus.wb_in[3]}}};

    assign w_wr      = w_hit && (bus.wb_in != 4'b0000);
    assign w_wr_cfg  = w_wr && ((w_off == OFF_DEST) || (w_off == OFF_SRC) || (w_off == OFF_SIZE));
    assign w_wr_cmd  = w_wr && (w_off == OFF_CMD);
    assign w_wr_stat = w_wr && (w_off == OFF_STATUS);
    assign w_idle    = (r_state == S_IDLE);

    assign w_set_send = (r_state == S_BUSY) && bus.send_done_in;
    assign w_set_err  = (w_wr_cfg && !w_idle) || (w_wr_cmd && (!w_idle || (r_size == '0)));
    assign w_clr_send = w_wr_stat && w_wdata[31];
    assign w_clr_recv = w_wr_stat && w_wdata[30];
    assign w_clr_err  = w_wr_stat && w_wdata[26];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_start    <= 1'b0;
            r_dest     <= '0;
            r_src      <= '0;
            r_size     <= '0;
            r_irq_send <= 1'b0;
            r_irq_recv <= 1'b0;
            r_err      <= 1'b0;
            r_rd_hit   <= 1'b0;
            r_rd_off   <= '0;
        end else begin
            r_rd_hit <= w_hit;
            r_rd_off <= w_off;

            // Descriptor is frozen while a send is outstanding.
            if (w_wr_cfg && w_idle) begin
                case (w_off)
                    OFF_DEST: r_dest <= (r_dest & ~w_mask) | (w_wdata & w_mask);
                    OFF_SRC:  r_src  <= (r_src  & ~w_mask) | (w_wdata & w_mask);
                    OFF_SIZE: r_size <= (r_size & ~w_mask) | (w_wdata & w_mask);
                    default:  ;
                endcase
            end

            case (r_state)
                S_IDLE: begin
                    if (w_wr_cmd && (r_size != '0) && (w_wdata != 32'h0)) begin
                        r_state <= S_REQ;
                        r_start <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus.start_ack_in) begin
                        r_state <= S_BUSY;
                        r_start <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (bus.send_done_in) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_start <= 1'b0;
                end
            endcase

            // Set events win over a same-cycle write-1-to-clear.
            r_irq_send <= w_set_send       | (r_irq_send & ~w_clr_send);
            r_irq_recv <= bus.recv_done_in | (r_irq_recv & ~w_clr_recv);
            r_err      <= w_set_err        | (r_err      & ~w_clr_err);
        end
    end

    assign w_status = {r_irq_send, r_irq_recv, r_state, r_err, 26'b0};

    // Read mux uses the registered offset but the current register contents.
    always_comb begin
        w_rd_word = 32'h0;
        if (r_rd_hit) begin
            case (r_rd_off)
                OFF_ID:     w_rd_word = ADDRESS;
                OFF_DEST:   w_rd_word = r_dest;
                OFF_SRC:    w_rd_word = r_src;
                OFF_SIZE:   w_rd_word = r_size;
                OFF_STATUS: w_rd_word = w_status;
                default:    w_rd_word = 32'h0;
            endcase
        end
    end

    assign bus.data_out     = f_swap(w_rd_word);
    assign bus.dest_out     = r_dest;
    assign bus.addr_out     = r_src;
    assign bus.size_out     = r_size;
    assign bus.start_out    = r_start;
    assign bus.irq_send_out = r_irq_send;
    assign bus.irq_recv_out = r_irq_recv;
    assign bus.err_out      = r_err;

endmodule

// File: tb/tb_ddma_mmio_regs.sv
module tb_ddma_mmio_regs;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam logic [31:0] NODE = 32'h0000_0102;

    logic clock = 1'b0;
    logic reset = 1'b1;

    ddma_mmio_regs_if bus();

    ddma_mmio_regs #(
        .MEMORY_WIDTH(32),
        .ADDRESS     (NODE),
        .BASE_ADDR   (BASE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
        logic [31:0] dest;
        logic [31:0] src;
        logic [31:0] size;
        logic        start;
        logic        irq_s;
        logic        irq_r;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc_n  = 0;

    always @(posedge clock) cyc_n <= cyc_n + 1;

    // Reference model: registers in register byte order, state as 0/1/2.
    bit [31:0] m_dest, m_src, m_size;
    int        m_state;
    bit        m_irq_s, m_irq_r, m_err;
    bit        m_rd_hit;
    int        m_rd_off;

    function automatic bit [31:0] swap32(input bit [31:0] w);
        bit [31:0] r;
        for (int k = 0; k < 4; k++) r[8*(3-k) +: 8] = w[8*k +: 8];
        return r;
    endfunction

    function automatic bit [31:0] reg_view(input int off);
        case (off)
            0: return NODE;
            1: return m_dest;
            2: return m_src;
            3: return m_size;
            5: return (32'(m_irq_s) << 31) | (32'(m_irq_r) << 30) |
                      (32'(m_state) << 27) | (32'(m_err) << 26);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step(input bit rst, input bit [31:0] a, input bit [31:0] d,
                              input bit [3:0] wb, input bit ack, input bit sd, input bit rd);
        int        old;
        bit        hit;
        int        off;
        bit [31:0] sw;
        bit [31:0] v;
        bit        se, ss, cs, cr, ce;
        if (rst) begin
            m_dest = 0; m_src = 0; m_size = 0; m_state = 0;
            m_irq_s = 0; m_irq_r = 0; m_err = 0; m_rd_hit = 0; m_rd_off = 0;
            return;
        end
        old = m_state;
        hit = ((a & ~32'h3) >= BASE) && ((a & ~32'h3) <= BASE + 32'd20);
        off = hit ? int'((a - BASE) / 4) : 0;
        sw  = swap32(d);
        se = 0; ss = 0; cs = 0; cr = 0; ce = 0;
        if (hit && wb != 0) begin
            case (off)
                1, 2, 3: begin
                    if (old != 0) se = 1;
                    else begin
                        v = reg_view(off);
                        for (int k = 0; k < 4; k++)
                            if (wb[k]) v[8*(3-k) +: 8] = d[8*k +: 8];
                        if (off == 1) m_dest = v;
                        else if (off == 2) m_src = v;
                        else m_size = v;
                    end
                end
                4: begin
                    if (old != 0 || m_size == 0) se = 1;
                    else if (sw != 0) m_state = 1;
                end
                5: begin
                    cs = sw[31]; cr = sw[30]; ce = sw[26];
                end
                default: ;
            endcase
        end
        if (old == 1 && ack) m_state = 2;
        if (old == 2 && sd) begin m_state = 0; ss = 1; end
        m_irq_s  = ss | (m_irq_s & !cs);
        m_irq_r  = rd | (m_irq_r & !cr);
        m_err    = se | (m_err & !ce);
        m_rd_hit = hit;
        m_rd_off = off;
    endtask

    // Drive one cycle of inputs on the falling edge; queue the state the DUT
    // must show after the next rising edge.
    task automatic step(input bit rst, input bit [31:0] a, input bit [31:0] d,
                        input bit [3:0] wb, input bit ack, input bit sd, input bit rd);
        exp_t e;
        @(negedge clock);
        reset            = rst;
        bus.addr_in      = a;
        bus.data_in      = d;
        bus.wb_in        = wb;
        bus.start_ack_in = ack;
        bus.send_done_in = sd;
        bus.recv_done_in = rd;
        model_step(rst, a, d, wb, ack, sd, rd);
        e.cyc   = cyc_n + 1;
        e.data  = m_rd_hit ? swap32(reg_view(m_rd_off)) : 32'h0;
        e.dest  = m_dest;
        e.src   = m_src;
        e.size  = m_size;
        e.start = (m_state == 1);
        e.irq_s = m_irq_s;
        e.irq_r = m_irq_r;
        e.err   = m_err;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        step(0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents a full output set.
    always @(negedge clock) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc == cyc_n) begin
            e = sb_q.pop_front();
            checks++;
            if (bus.data_out !== e.data || bus.dest_out !== e.dest || bus.addr_out !== e.src ||
                bus.size_out !== e.size || bus.start_out !== e.start ||
                bus.irq_send_out !== e.irq_s || bus.irq_recv_out !== e.irq_r ||
                bus.err_out !== e.err) begin
                errors++;
                $display("FAIL sb cyc=%0d got data=%h dest=%h src=%h size=%h st=%b is=%b ir=%b er=%b want data=%h dest=%h src=%h size=%h st=%b is=%b ir=%b er=%b",
                         cyc_n, bus.data_out, bus.dest_out, bus.addr_out, bus.size_out,
                         bus.start_out, bus.irq_send_out, bus.irq_recv_out, bus.err_out,
                         e.data, e.dest, e.src, e.size, e.start, e.irq_s, e.irq_r, e.err);
            end
        end
    end

    // Fixed expectations for the directed scenarios, sampled after the edge.
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, expv);
        end
    endtask

    task automatic after_edge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit [31:0] a;
        bit [31:0] d;
        bit [3:0]  wb;
        bus.addr_in = 0; bus.data_in = 0; bus.wb_in = 0;
        bus.start_ack_in = 0; bus.send_done_in = 0; bus.recv_done_in = 0;

        repeat (3) step(1, $urandom, $urandom, 4'hF, 1, 1, 1);
        after_edge();
        chk("rst_data", bus.data_out, 32'h0);
        chk("rst_desc", bus.dest_out | bus.addr_out | bus.size_out, 32'h0);
        chk("rst_flags", {28'h0, bus.start_out, bus.irq_send_out, bus.irq_recv_out, bus.err_out}, 32'h0);

        step(0, BASE, 32'h0, 4'h0, 0, 0, 0);
        after_edge();
        chk("id_read", bus.data_out, 32'h0201_0000);

        step(0, BASE + 4, 32'h1100_0000, 4'hF, 0, 0, 0);
        after_edge();
        chk("dest_wr", bus.dest_out, 32'h0000_0011);

        step(0, BASE + 12, 32'h0000_0005, 4'h1, 0, 0, 0);
        after_edge();
        chk("size_lane", bus.size_out, 32'h0500_0000);

        step(0, BASE + 12, 32'h0400_0000, 4'hF, 0, 0, 0);
        after_edge();
        chk("size_4", bus.size_out, 32'h0000_0004);

        step(0, BASE + 16, 32'h0100_0000, 4'hF, 0, 0, 0);
        after_edge();
        chk("start_req", {31'h0, bus.start_out}, 32'h1);
        idle();
        idle();
        after_edge();
        chk("start_hold", {31'h0, bus.start_out}, 32'h1);
        step(0, 32'h0, 32'h0, 4'h0, 1, 0, 0);
        after_edge();
        chk("start_drop", {31'h0, bus.start_out}, 32'h0);

        step(0, BASE + 20, 32'h0, 4'h0, 0, 0, 0);
        after_edge();
        chk("status_busy", bus.data_out, 32'h0000_0010);

        step(0, BASE + 4, 32'hFF00_0000, 4'hF, 0, 0, 0);
        after_edge();
        chk("dest_locked", bus.dest_out, 32'h0000_0011);
        chk("err_set", {31'h0, bus.err_out}, 32'h1);
        step(0, BASE + 16, 32'h0100_0000, 4'hF, 0, 0, 0);
        step(0, BASE + 20, 32'h0000_0004, 4'hF, 0, 0, 0);
        after_edge();
        chk("err_w1c", {31'h0, bus.err_out}, 32'h0);

        step(0, 32'h0, 32'h0, 4'h0, 0, 1, 0);
        after_edge();
        chk("irq_send", {31'h0, bus.irq_send_out}, 32'h1);
        step(0, BASE + 20, 32'h0, 4'h0, 0, 0, 0);
        after_edge();
        chk("status_irq", bus.data_out, 32'h0000_0080);

        step(0, 32'h0, 32'h0, 4'h0, 0, 0, 1);
        step(0, BASE + 20, 32'h0000_0040, 4'hF, 0, 0, 1);
        after_edge();
        chk("recv_collide", {31'h0, bus.irq_recv_out}, 32'h1);
        step(0, BASE + 20, 32'h0000_0040, 4'hF, 0, 0, 0);
        after_edge();
        chk("recv_clear", {31'h0, bus.irq_recv_out}, 32'h0);

        step(0, BASE + 16, 32'h0100_0000, 4'hF, 0, 0, 0);
        step(1, 32'h0, 32'h0, 4'h0, 0, 0, 0);
        after_edge();
        chk("rst_req", {31'h0, bus.start_out}, 32'h0);
        step(0, BASE + 20, 32'h0, 4'h0, 0, 0, 0);
        after_edge();
        chk("rst_idle", bus.data_out, 32'h0);
        step(0, BASE + 16, 32'h0100_0000, 4'hF, 0, 0, 0);
        after_edge();
        chk("size0_err", {31'h0, bus.err_out}, 32'h1);
        chk("size0_nostart", {31'h0, bus.start_out}, 32'h0);

        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 9))
                0: a = $urandom;
                1: a = BASE - 32'd4 + 32'($urandom_range(0, 3));
                2: a = BASE + 32'h18 + 32'($urandom_range(0, 7));
                default: a = BASE + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
            endcase
            d  = $urandom;
            wb = ($urandom_range(0, 9) < 3) ? 4'h0 : 4'($urandom_range(1, 15));
            step($urandom_range(0, 59) == 0, a, d, wb,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0);
        end
        idle();
        repeat (3) @(negedge clock);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain left=%0d want=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
